// File: rtl/pseq_pkg.sv
// pseq_pkg: shared types and constants for phase_sequencer and pseq_stream.
//   phase_e  : testcase phase encoding carried in marker inst[23:21]
//   state_e  : per-source bracketing FSM state
//   ERR_*    : err_code values
//   MK_*     : marker match constants, is_marker() applies them to one lane
package pseq_pkg;

  typedef enum logic [2:0] {
    PH_VCTM  = 3'd0,
    PH_DELAY = 3'd1,
    PH_TEXE  = 3'd2,
    PH_LEAK  = 3'd3,
    PH_INIT  = 3'd4,
    PH_BIM   = 3'd5,
    PH_TRAIN = 3'd6
  } phase_e;

  typedef enum logic [1:0] {
    ST_OUT,
    ST_IN,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_ORDER  = 3'd1;
  localparam logic [2:0] ERR_WDOG   = 3'd2;
  localparam logic [2:0] ERR_DESYNC = 3'd3;
  localparam logic [2:0] ERR_SKEW   = 3'd4;
  localparam logic [2:0] ERR_MULTI  = 3'd5;

  localparam logic [19:0] MK_LO_VAL  = 20'h02013;
  localparam logic [7:0]  MK_HI_VAL  = 8'h00;
  localparam logic [2:0]  MK_PH_RSVD = 3'd7;

  function automatic logic is_marker(input logic [31:0] inst);
    return (inst[19:0] == MK_LO_VAL) && (inst[31:24] == MK_HI_VAL) &&
           (inst[23:21] != MK_PH_RSVD);
  endfunction

endpackage

// File: rtl/pseq_stream.sv
// pseq_stream: marker decode plus bracketing FSM for one commit source.
//   clock, reset_n     : clock, async active-low reset
//   valid, inst        : per-lane commit valid / instruction (lane i = inst[32i+31:32i])
//   mk_any             : a marker was decoded this cycle (lowest lane wins)
//   mk_legal           : that marker was a legal START/END for the current state
//   mk_phase, mk_end   : decoded fields of the selected marker
//   order_err          : illegal bracketing this cycle
//   multi_err          : more than one marker lane this cycle
//   state, phase       : registered FSM state and current phase
module pseq_stream
  import pseq_pkg::*;
#(
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [COMMIT_W-1:0]     valid,
  input  logic [32*COMMIT_W-1:0]  inst,
  output logic                    mk_any,
  output logic                    mk_legal,
  output phase_e                  mk_phase,
  output logic                    mk_end,
  output logic                    order_err,
  output logic                    multi_err,
  output state_e                  state,
  output phase_e                  phase
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic        vbit;
  logic [31:0] lane;

  always_comb begin
    mk_any    = 1'b0;
    multi_err = 1'b0;
    mk_phase  = PH_VCTM;
    mk_end    = 1'b0;
    vbit      = 1'b0;
    lane      = '0;
    for (int unsigned i = 0; i < COMMIT_W; i++) begin
      vbit = |((valid >> i) & COMMIT_W'(1));
      lane = 32'(inst >> (32 * i));
      if (vbit && is_marker(lane)) begin
        if (mk_any) begin
          multi_err = 1'b1;
        end else begin
          mk_any   = 1'b1;
          mk_phase = phase_e'(lane[23:21]);
          mk_end   = lane[20];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    mk_legal  = 1'b0;
    order_err = 1'b0;
    if (mk_any) begin
      case (state_q)
        ST_OUT: begin
          if (!mk_end) begin
            state_d  = ST_IN;
            phase_d  = mk_phase;
            mk_legal = 1'b1;
          end else begin
            order_err = 1'b1;
          end
        end
        ST_IN: begin
          if (mk_end && (mk_phase == phase_q)) begin
            mk_legal = 1'b1;
            state_d  = (phase_q == PH_LEAK) ? ST_DONE : ST_OUT;
          end else begin
            order_err = 1'b1;
          end
        end
        default: ;
      endcase
      if (order_err) state_d = ST_ERR;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OUT;
      phase_q <= PH_VCTM;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  assign state = state_q;
  assign phase = phase_q;

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: tracks testcase phase markers on the DUT (and optionally
// variant) commit stream, reports per-phase cycle counts, flags done/error.
// Optional feature macro: PSEQ_VARIANT_EN (variant FSM, marker FIFOs, skew check).
//   clock, reset_n       : clock, async active-low reset
//   dut_valid/dut_inst   : DUT commit lanes
//   vnt_valid/vnt_inst   : variant commit lanes (ignored without PSEQ_VARIANT_EN)
//   dut_phase            : {inside, phase} of the DUT stream
//   rpt_valid/phase/cycles : one-cycle report after each legal DUT END
//   done, err, err_code  : sticky completion / first-error status
module phase_sequencer
  import pseq_pkg::*;
#(
  parameter int unsigned COMMIT_W    = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned MAX_SKEW    = 4096,
  parameter int unsigned WDOG_CYCLES = 1000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [COMMIT_W-1:0]    dut_valid,
  input  logic [32*COMMIT_W-1:0] dut_inst,
  input  logic [COMMIT_W-1:0]    vnt_valid,
  input  logic [32*COMMIT_W-1:0] vnt_inst,
  output logic [3:0]             dut_phase,
  output logic                   rpt_valid,
  output logic [2:0]             rpt_phase,
  output logic [CNT_W-1:0]       rpt_cycles,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             err_code
);

  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

  logic   d_any, d_legal, d_end, d_order, d_multi;
  phase_e d_ph, d_cur_ph;
  state_e d_state;

  pseq_stream #(.COMMIT_W(COMMIT_W)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid     (dut_valid),
    .inst      (dut_inst),
    .mk_any    (d_any),
    .mk_legal  (d_legal),
    .mk_phase  (d_ph),
    .mk_end    (d_end),
    .order_err (d_order),
    .multi_err (d_multi),
    .state     (d_state),
    .phase     (d_cur_ph)
  );

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rpt_valid_q, rpt_valid_d;
  logic [2:0]       rpt_phase_q, rpt_phase_d;
  logic [CNT_W-1:0] rpt_cycles_q, rpt_cycles_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             wdog_hit;
  logic             done_q, done_d, done_set;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             vnt_order, vnt_multi, desync, skew_err;

  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    if (d_legal && !d_end)     cnt_d = '0;
    else if (d_state == ST_IN) cnt_d = cnt_inc;

    // The END cycle itself counts as a cycle inside the phase.
    rpt_valid_d  = d_legal && d_end;
    rpt_phase_d  = rpt_phase_q;
    rpt_cycles_d = rpt_cycles_q;
    if (rpt_valid_d) begin
      rpt_phase_d  = d_ph;
      rpt_cycles_d = cnt_inc;
    end

    wd_d = wd_q;
    if (d_any)                              wd_d = '0;
    else if (wd_q != WD_W'(WDOG_CYCLES))    wd_d = wd_q + WD_W'(1);
    wdog_hit = (wd_d == WD_W'(WDOG_CYCLES)) && (d_state != ST_DONE);

    // First cause wins; simultaneous causes resolve to the lowest code.
    err_d  = err_q;
    code_d = code_q;
    if (!err_q) begin
      err_d = 1'b1;
      if (d_order || vnt_order)      code_d = ERR_ORDER;
      else if (wdog_hit)             code_d = ERR_WDOG;
      else if (desync)               code_d = ERR_DESYNC;
      else if (skew_err)             code_d = ERR_SKEW;
      else if (d_multi || vnt_multi) code_d = ERR_MULTI;
      else                           err_d  = 1'b0;
    end

    done_d = done_q | done_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      rpt_valid_q  <= 1'b0;
      rpt_phase_q  <= '0;
      rpt_cycles_q <= '0;
      wd_q         <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
    end else begin
      cnt_q        <= cnt_d;
      rpt_valid_q  <= rpt_valid_d;
      rpt_phase_q  <= rpt_phase_d;
      rpt_cycles_q <= rpt_cycles_d;
      wd_q         <= wd_d;
      done_q       <= done_d;
      err_q        <= err_d;
      code_q       <= code_d;
    end
  end

  assign dut_phase  = (d_state == ST_IN) ? {1'b1, d_cur_ph} : 4'b0000;
  assign rpt_valid  = rpt_valid_q;
  assign rpt_phase  = rpt_phase_q;
  assign rpt_cycles = rpt_cycles_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

`ifdef PSEQ_VARIANT_EN
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned SK_W = $clog2(MAX_SKEW + 1);

  logic   v_any, v_legal, v_end;
  phase_e v_ph, v_cur_ph;
  state_e v_state;

  pseq_stream #(.COMMIT_W(COMMIT_W)) u_vnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid     (vnt_valid),
    .inst      (vnt_inst),
    .mk_any    (v_any),
    .mk_legal  (v_legal),
    .mk_phase  (v_ph),
    .mk_end    (v_end),
    .order_err (vnt_order),
    .multi_err (vnt_multi),
    .state     (v_state),
    .phase     (v_cur_ph)
  );

  // Index 0 holds DUT markers, index 1 variant markers; entries are {phase, end}.
  logic [3:0]      mem_q [2][FIFO_DEPTH];
  logic [3:0]      mem_d [2][FIFO_DEPTH];
  logic [AW-1:0]   wr_q [2], wr_d [2], rd_q [2], rd_d [2];
  logic [AW:0]     fcnt_q [2], fcnt_d [2];
  logic [SK_W-1:0] skew_q, skew_d;
  logic [3:0]      entry [2];
  logic [1:0]      push, ne, full;
  logic            pop, do_push, overflow;
  logic            unused_vnt;

  always_comb begin
    push     = {v_legal, d_legal};
    entry[0] = {d_ph, d_end};
    entry[1] = {v_ph, v_end};
    ne       = {fcnt_q[1] != '0, fcnt_q[0] != '0};
    full     = {fcnt_q[1] == (AW+1)'(FIFO_DEPTH), fcnt_q[0] == (AW+1)'(FIFO_DEPTH)};
    pop      = ne[0] && ne[1];
    desync   = pop && (mem_q[0][rd_q[0]] != mem_q[1][rd_q[1]]);
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    fcnt_d   = fcnt_q;
    do_push  = 1'b0;
    overflow = 1'b0;
    for (int unsigned s = 0; s < 2; s++) begin
      // A simultaneous pop frees a slot, so a full FIFO may still accept.
      do_push = push[s[0]] && (!full[s[0]] || pop);
      if (push[s[0]] && !do_push) overflow = 1'b1;
      if (do_push) begin
        mem_d[s[0]][wr_q[s[0]]] = entry[s[0]];
        wr_d[s[0]] = wr_q[s[0]] + AW'(1);
      end
      if (pop) rd_d[s[0]] = rd_q[s[0]] + AW'(1);
      fcnt_d[s[0]] = fcnt_q[s[0]] + (AW+1)'(do_push) - (AW+1)'(pop);
    end

    skew_d = skew_q;
    if (pop || !(ne[0] || ne[1]))          skew_d = '0;
    else if (skew_q != SK_W'(MAX_SKEW))    skew_d = skew_q + SK_W'(1);
    skew_err = overflow || (skew_d == SK_W'(MAX_SKEW));

    done_set = (d_state == ST_DONE) && (v_state == ST_DONE) && !ne[0] && !ne[1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '{default: '0};
      rd_q   <= '{default: '0};
      fcnt_q <= '{default: '0};
      skew_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
      skew_q <= skew_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign unused_vnt = ^{v_any, v_cur_ph};
`else
  logic unused_vnt;

  assign vnt_order  = 1'b0;
  assign vnt_multi  = 1'b0;
  assign desync     = 1'b0;
  assign skew_err   = 1'b0;
  assign done_set   = d_legal && d_end && (d_ph == PH_LEAK);
  assign unused_vnt = ^{vnt_valid, vnt_inst, FIFO_DEPTH[0], MAX_SKEW[0]};
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scoreboard bench for phase_sequencer.
// Stimulus pushes expected reports / error codes into queues; a monitor
// process pops and compares whenever rpt_valid pulses or err rises.
module tb_phase_sequencer;

  localparam logic [2:0] VCTM  = 3'd0;
  localparam logic [2:0] DELAY = 3'd1;
  localparam logic [2:0] TEXE  = 3'd2;
  localparam logic [2:0] LEAK  = 3'd3;
  localparam logic [2:0] INIT  = 3'd4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  dut_valid = '0;
  logic [63:0] dut_inst = '0;
  logic [1:0]  vnt_valid = '0;
  logic [63:0] vnt_inst = '0;
  logic [3:0]  dut_phase;
  logic        rpt_valid;
  logic [2:0]  rpt_phase;
  logic [31:0] rpt_cycles;
  logic        done;
  logic        err;
  logic [2:0]  err_code;

  always #5 clock = ~clock;

  phase_sequencer #(
    .COMMIT_W    (2),
    .FIFO_DEPTH  (8),
    .MAX_SKEW    (16),
    .WDOG_CYCLES (100),
    .CNT_W       (32)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .dut_valid  (dut_valid),
    .dut_inst   (dut_inst),
    .vnt_valid  (vnt_valid),
    .vnt_inst   (vnt_inst),
    .dut_phase  (dut_phase),
    .rpt_valid  (rpt_valid),
    .rpt_phase  (rpt_phase),
    .rpt_cycles (rpt_cycles),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  typedef struct packed {
    logic [2:0]  ph;
    logic [31:0] cyc;
  } rpt_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  rpt_t        rpt_q[$];
  logic [2:0]  errq[$];
  logic        mirror = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] ph, input logic e);
    return {8'h00, ph, e, 20'h02013};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] i0, input logic v0, input logic [31:0] i1, input logic v1);
    dut_inst  = {i1, i0};
    dut_valid = {v1, v0};
    if (mirror) begin
      vnt_inst  = {i1, i0};
      vnt_valid = {v1, v0};
    end
    step();
    dut_valid = '0;
    vnt_valid = '0;
  endtask

  task automatic mark(input logic [2:0] ph, input logic e);
    drive(mk(ph, e), 1'b1, 32'h0, 1'b0);
  endtask

  task automatic bracket(input logic [2:0] ph, input int unsigned gap);
    rpt_q.push_back({ph, 32'(gap + 1)});
    mark(ph, 1'b0);
    repeat (gap) step();
    mark(ph, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dut_phase"},  32'(dut_phase),  32'h0);
    check({tag, "_rpt_valid"},  32'(rpt_valid),  32'h0);
    check({tag, "_rpt_phase"},  32'(rpt_phase),  32'h0);
    check({tag, "_rpt_cycles"}, rpt_cycles,      32'h0);
    check({tag, "_done"},       32'(done),       32'h0);
    check({tag, "_err"},        32'(err),        32'h0);
    check({tag, "_err_code"},   32'(err_code),   32'h0);
  endtask

  task automatic do_reset();
    check("drained_rpt", 32'(rpt_q.size()), 32'h0);
    check("drained_err", 32'(errq.size()), 32'h0);
    reset_n = 1'b0;
    dut_valid = '0;
    vnt_valid = '0;
    #1;
    check_zero("reset");
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic legal_seq();
    // INIT start on lane0 with a phase-7 lookalike on lane1 (not a marker)
    rpt_q.push_back({INIT, 32'd10});
    drive(mk(INIT, 1'b0), 1'b1, 32'h00E02013, 1'b1);
    check("init_inside", 32'(dut_phase), 32'hC);
    repeat (9) step();
    // INIT end on lane1; lane0 has a nonzero top byte so it is not a marker
    drive(32'h01902013, 1'b1, mk(INIT, 1'b1), 1'b1);
    check("init_closed", 32'(dut_phase), 32'h0);
    bracket(VCTM, 2);
    bracket(DELAY, 0);
    bracket(TEXE, 4);
    bracket(LEAK, 0);
    repeat (3) step();
    check("seq_done", 32'(done), 32'h1);
    check("seq_err",  32'(err),  32'h0);
  endtask

  // Monitor: compares DUT reports and error events against the queues.
  initial begin
    rpt_t       e;
    logic [2:0] ec;
    logic       prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clock);
      if (rpt_valid) begin
        if (rpt_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rpt: got phase %0d cycles %0d, expected none", rpt_phase, rpt_cycles);
        end else begin
          e = rpt_q.pop_front();
          check("rpt_phase",  32'(rpt_phase), 32'(e.ph));
          check("rpt_cycles", rpt_cycles,     e.cyc);
        end
      end
      if (err && !prev_err) begin
        if (errq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_err: got err_code %0d, expected no error", err_code);
        end else begin
          ec = errq.pop_front();
          check("mon_err_code", 32'(err_code), 32'(ec));
        end
      end
      prev_err = err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no end of run, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    do_reset();

    // Legal sequence, then a marker after DONE is ignored
    legal_seq();
    mark(VCTM, 1'b0);
    check("done_ignores_phase", 32'(dut_phase), 32'h0);
    check("done_ignores_err",   32'(err),       32'h0);

    // ORDER: VCTM start then TEXE end
    do_reset();
    errq.push_back(3'd1);
    mark(VCTM, 1'b0);
    check("order_inside", 32'(dut_phase), 32'h8);
    mark(TEXE, 1'b1);
    repeat (3) step();
    check("order_err",       32'(err),       32'h1);
    check("order_code",      32'(err_code),  32'h1);
    check("order_err_phase", 32'(dut_phase), 32'h0);

    // MULTI: two marker lanes in one cycle, lane0 wins
    do_reset();
    errq.push_back(3'd5);
    drive(mk(INIT, 1'b0), 1'b1, mk(INIT, 1'b1), 1'b1);
    check("multi_phase", 32'(dut_phase), 32'hC);
    check("multi_code",  32'(err_code),  32'h5);
    repeat (2) step();

    // Watchdog: 100 cycles without a marker
    do_reset();
    errq.push_back(3'd2);
    mark(INIT, 1'b0);
    repeat (99) step();
    check("wdog_before", 32'(err), 32'h0);
    step();
    check("wdog_err",  32'(err),      32'h1);
    check("wdog_code", 32'(err_code), 32'h2);
    repeat (2) step();

    // Reset asserted mid-phase with err set, then a clean rerun
    do_reset();
    errq.push_back(3'd1);
    mark(INIT, 1'b0);
    mark(VCTM, 1'b0);
    repeat (2) step();
    check("mid_err_set", 32'(err), 32'h1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("async");
    repeat (2) step();
    reset_n = 1'b1;
    step();
    legal_seq();

`ifdef PSEQ_VARIANT_EN
    // DESYNC: DUT and variant start different phases
    do_reset();
    mirror = 1'b0;
    errq.push_back(3'd3);
    dut_inst  = {32'h0, mk(VCTM, 1'b0)};
    dut_valid = 2'b01;
    vnt_inst  = {32'h0, mk(DELAY, 1'b0)};
    vnt_valid = 2'b01;
    step();
    dut_valid = '0;
    vnt_valid = '0;
    check("desync_before", 32'(err), 32'h0);
    step();
    check("desync_err",  32'(err),      32'h1);
    check("desync_code", 32'(err_code), 32'h3);
    repeat (2) step();

    // SKEW: variant never answers the DUT marker
    do_reset();
    errq.push_back(3'd4);
    mark(INIT, 1'b0);
    repeat (15) step();
    check("skew_before", 32'(err), 32'h0);
    step();
    check("skew_err",  32'(err),      32'h1);
    check("skew_code", 32'(err_code), 32'h4);
    repeat (2) step();
    mirror = 1'b1;
`endif

    repeat (2) step();
    check("final_rpt_drained", 32'(rpt_q.size()), 32'h0);
    check("final_err_drained", 32'(errq.size()),  32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Decodes fuzzing-testcase marker instructions from the DUT commit stream and, optionally, the variant commit stream.
- Enforces legal phase bracketing on each stream.
- Checks that DUT and variant reach identical marker sequences within a skew window.
- Reports per-phase cycle counts and raises done, error or timeout so the bench can terminate a run. Sits beside the simulation sync/taint monitor in the harness.

Parameters:
- COMMIT_W, 2, commit lanes per source.
- FIFO_DEPTH, 8, unmatched-marker FIFO depth per source (power of 2).
- MAX_SKEW, 4096, maximum cycles a marker may wait for its counterpart on the other stream.
- WDOG_CYCLES, 1000000, maximum cycles between consecutive DUT markers.
- CNT_W, 32, cycle-counter width.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- dut_valid  in  COMMIT_W  per-lane DUT commit valid.
- dut_inst  in  32*COMMIT_W  per-lane DUT committed instruction; lane i is bits [32i+31:32i].
- vnt_valid  in  COMMIT_W  per-lane variant commit valid.
- vnt_inst  in  32*COMMIT_W  per-lane variant committed instruction.
- dut_phase  out  4  {inside, phase[2:0]} of the DUT stream.
- rpt_valid  out  1  one-cycle pulse on each legal DUT END marker.
- rpt_phase  out  3  phase just closed.
- rpt_cycles  out  CNT_W  cycles spent inside that phase.
- done  out  1  sticky; set by a legal DUT LEAK_END.
- err  out  1  sticky error.
- err_code  out  3  first error cause.

Behaviour:
- Reset: all outputs 0. FSMs go to OUT, FIFOs are emptied, counters are cleared.
- Marker decode:
  - A valid lane is a marker iff inst[19:0]==20'h02013, inst[31:24]==0 and inst[23:21]!=7.
  - phase=inst[23:21] (VCTM0 DELAY1 TEXE2 LEAK3 INIT4 BIM5 TRAIN6); end=inst[20].
  - Only the lowest-index marker lane per source per cycle is processed. A second marker in the same cycle sets err_code=5 (MULTI).
- Per-source FSM states: OUT, IN(p), DONE, ERR.
  - OUT + START p -> IN(p).
  - IN(p) + END p -> OUT. If p==LEAK the FSM goes to DONE instead.
  - START while IN, or END with a mismatched phase -> ERR, err_code=1 (ORDER).
  - DONE ignores further markers.
  - ERR is terminal until reset.
- DUT phase counter:
  - Cleared on START and incremented every cycle while IN.
  - On the END cycle, rpt_cycles = counter+1 and rpt_valid pulses in the following cycle (registered, latency 1).
  - The counter saturates at all-ones.
- Watchdog:
  - Counts cycles since the last DUT marker; reset by any DUT marker.
  - Reaching WDOG_CYCLES with the DUT FSM not in DONE sets err_code=2 (WDOG).
- err/err_code latch the first cause only. If two causes occur in the same cycle, the lowest code wins.
- done and err may both be 1; the bench treats err as dominant.
- Reset asserted mid-run clears everything asynchronously, including sticky flags.

Optional Feature:
- PSEQ_VARIANT_EN defined:
  - The variant stream runs its own FSM.
  - Each legal marker {phase,end} of each source is pushed into that source's FIFO.
  - When both FIFOs are non-empty, their heads pop together. Unequal heads set err_code=3 (DESYNC).
  - A skew counter runs while exactly one FIFO is non-empty and clears when both are empty or a pop occurs; reaching MAX_SKEW sets err_code=4 (SKEW).
  - A push to a full FIFO sets err_code=4.
  - A variant ORDER error sets err_code=1.
  - done requires both FSMs in DONE and both FIFOs empty.
- PSEQ_VARIANT_EN undefined:
  - vnt_* inputs are ignored; no FIFOs or skew logic are built.
  - Codes 3 and 4 are never produced.
  - done follows the DUT FSM alone.

Decomposition:
- Shared package pseq_pkg holds:
  - phase enum (VCTM..TRAIN);
  - fsm state enum;
  - err_code constants (NONE0 ORDER1 WDOG2 DESYNC3 SKEW4 MULTI5);
  - marker match mask/value constants.
- One sub-module, pseq_stream: marker decode plus per-source FSM, instantiated for DUT and, under PSEQ_VARIANT_EN, for the variant. The FIFOs and skew/watchdog logic live in the top.

Test Plan:
- Legal sequence: INIT_START (0x00802013), INIT_END 10 cycles later, then VCTM, DELAY, TEXE, LEAK brackets -> rpt_valid pulses with rpt_cycles=10 for INIT, done=1, err=0.
- ORDER: DUT commits VCTM_START, then TEXE_END -> err=1, err_code=1, and no rpt_valid for TEXE.
- MULTI: lane0=INIT_START and lane1=INIT_END in the same cycle -> err_code=5. The FSM takes lane0 only, so dut_phase={1,4}.
- Watchdog: with WDOG_CYCLES=100, assert INIT_START and then no further markers -> err_code=2 at cycle 100 after the marker.
- With PSEQ_VARIANT_EN: DUT sends VCTM_START while the variant sends DELAY_START -> err_code=3. In a separate run, the variant lags by MAX_SKEW=16 cycles -> err_code=4.
- Reset_n pulsed low mid-phase with err set -> all outputs 0 immediately. A subsequent legal sequence then completes with done=1.
